// File: rtl/rv_elastic_buffer.sv
// rtl/rv_elastic_buffer.sv - parametrised ready/valid elastic buffer with occupancy count, flush and optional bypass
//
// Purpose:
//   DEPTH-entry circular FIFO between an ingress and an egress ready/valid
//   pair. i_ready depends only on registered occupancy and flush. Without
//   bypass, e_valid/e_data depend only on registered state and flush.
//
// Optional feature macro: RV_ELASTIC_BUFFER_BYPASS_EN
//   When defined, an empty buffer presents the ingress word on the egress
//   side in the same cycle (0-cycle latency). If it is consumed directly it
//   is never written.
//
// Parameters:
//   DATA_W  payload width in bits (>=1)
//   DEPTH   entry count, power of two, >=2
//
// Ports:
//   clk      clock, all state on rising edge
//   rst      asynchronous active-high reset
//   flush    synchronous discard of all stored entries (wins over push/pop)
//   i_valid  ingress valid
//   i_ready  ingress ready
//   i_data   ingress payload
//   e_valid  egress valid
//   e_ready  egress ready
//   e_data   egress payload
//   count    registered occupancy, 0..DEPTH
module rv_elastic_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       e_valid,
  input  logic                       e_ready,
  output logic [DATA_W-1:0]          e_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Registered-state only: a full buffer never accepts in the cycle it pops.
  assign i_ready = !full && !flush;
  assign push    = i_valid && i_ready;
  assign pop     = e_valid && e_ready;

`ifdef RV_ELASTIC_BUFFER_BYPASS_EN
  logic bypass;

  assign bypass  = empty && !flush && i_valid;
  assign e_valid = bypass || (!empty && !flush);
  assign e_data  = empty ? i_data : mem[rd_ptr];
  // A bypassed word taken in the same cycle never touches storage.
  assign wr_en   = push && !(bypass && e_ready);
  assign rd_en   = pop && !bypass;
`else
  assign e_valid = !empty && !flush;
  assign e_data  = mem[rd_ptr];
  assign wr_en   = push;
  assign rd_en   = pop;
`endif

  assign count = cnt;

  // Payload storage is intentionally not reset or flushed; pointers gate it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// tb/tb_rv_elastic_buffer.sv - scoreboard bench for rv_elastic_buffer
module tb_rv_elastic_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              e_valid;
  logic              e_ready;
  logic [DATA_W-1:0] e_data;
  logic [CW-1:0]     count;

  rv_elastic_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .e_valid (e_valid),
    .e_ready (e_ready),
    .e_data  (e_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [DATA_W-1:0] model_q [$];
  int                occ       = 0;
  int                n_push    = 0;
  bit                push_flag = 0;
  bit                prev_hold = 0;
  logic [DATA_W-1:0] prev_data = '0;

`ifdef RV_ELASTIC_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    i_valid = 1'b0;
    e_ready = 1'b1;
    while (count != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain_done", count, 0);
    e_ready = 1'b0;
  endtask

  // Ingress recorder: every accepted word becomes an expected egress word.
  always @(negedge clk) begin
    push_flag = 1'b0;
    if (!rst && i_valid && i_ready) begin
      model_q.push_back(i_data);
      push_flag = 1'b1;
      n_push++;
    end
  end

  // Egress monitor: protocol rules and in-order data against the model.
  always @(negedge clk) begin
    bit popped;
    bit exp_ev;
    logic [DATA_W-1:0] exp_d;
    #1;
    popped = 1'b0;
    if (rst) begin
      model_q.delete();
      occ       = 0;
      prev_hold = 1'b0;
    end else begin
      chk("mon_count", count, occ);
      chk("mon_count_max", count <= DEPTH, 1);
      chk("mon_i_ready", i_ready, (!flush && occ < DEPTH));
      exp_ev = !flush && (occ > 0 || (BYPASS && i_valid));
      chk("mon_e_valid", e_valid, exp_ev);
      if (prev_hold && !flush) begin
        chk("mon_hold_valid", e_valid, 1);
        chk("mon_hold_data", e_data, prev_data);
      end
      if (e_valid && e_ready) begin
        popped = 1'b1;
        if (model_q.size() == 0) begin
          chk("mon_pop_nonempty", 0, 1);
        end else begin
          exp_d = model_q.pop_front();
          chk("mon_e_data", e_data, exp_d);
        end
      end
      if (flush) begin
        model_q.delete();
        occ = 0;
      end else begin
        occ = occ + int'(push_flag) - int'(popped);
      end
      prev_hold = e_valid && !e_ready && !flush;
      prev_data = e_data;
    end
  end

  initial begin
    int start;
    int w;
    int n;
    rst     = 1'b1;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    e_ready = 1'b0;
    step();
    step();
    chk("reset_i_ready", i_ready, 1);
    chk("reset_e_valid", e_valid, 0);
    chk("reset_count", count, 0);
    rst = 1'b0;

    // Single word 0xA5 with e_ready=1.
    i_valid = 1'b1;
    i_data  = 8'hA5;
    e_ready = 1'b1;
    #1;
    chk("single_push_cycle_e_valid", e_valid, BYPASS);
    if (BYPASS) chk("single_bypass_data", e_data, 8'hA5);
    step();
    i_valid = 1'b0;
    #1;
    chk("single_next_e_valid", e_valid, !BYPASS);
    chk("single_next_count", count, BYPASS ? 0 : 1);
    if (!BYPASS) chk("single_next_data", e_data, 8'hA5);
    step();
    chk("single_final_count", count, 0);
    chk("single_final_e_valid", e_valid, 0);

    // Fill to full with e_ready=0, then hold a 5th word.
    e_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      i_valid = 1'b1;
      i_data  = DATA_W'(i);
      step();
    end
    chk("full_i_ready", i_ready, 0);
    chk("full_count", count, 4);
    i_data = 8'h05;
    step();
    chk("full_hold_count", count, 4);
    chk("full_hold_i_ready", i_ready, 0);
    e_ready = 1'b1;
    #1;
    chk("full_pop_data", e_data, 8'h01);
    step();
    e_ready = 1'b0;
    #1;
    chk("after_pop_i_ready", i_ready, 1);
    chk("after_pop_count", count, 3);
    step();
    i_valid = 1'b0;
    chk("fifth_accepted_count", count, 4);
    drain(20);

    // Random streaming with 50% egress stalls.
    start = n_push;
    for (int c = 0; c < 20000 && (n_push - start) < 1000; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = DATA_W'($urandom);
      e_ready = $urandom_range(0, 1) == 1;
      step();
    end
    chk("stream_words", (n_push - start) >= 1000, 1);
    drain(50);

    // Wrap-around with fill-3/drain-3 phases over 10 words.
    w = 0;
    while (w < 10) begin
      n = (10 - w) < 3 ? (10 - w) : 3;
      e_ready = 1'b0;
      for (int j = 0; j < n; j++) begin
        i_valid = 1'b1;
        i_data  = DATA_W'(8'h10 + w);
        w++;
        step();
      end
      i_valid = 1'b0;
      chk("wrap_fill_count", count, n);
      e_ready = 1'b1;
      repeat (n) step();
      e_ready = 1'b0;
      chk("wrap_drain_count", count, 0);
    end

    // Flush with three stored and both sides valid.
    e_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_valid = 1'b1;
      i_data  = DATA_W'(8'hB0 + j);
      step();
    end
    chk("pre_flush_count", count, 3);
    i_data  = 8'h77;
    e_ready = 1'b1;
    flush   = 1'b1;
    #1;
    chk("flush_i_ready", i_ready, 0);
    chk("flush_e_valid", e_valid, 0);
    step();
    flush   = 1'b0;
    i_valid = 1'b0;
    e_ready = 1'b0;
    #1;
    chk("post_flush_count", count, 0);
    chk("post_flush_e_valid", e_valid, 0);
    i_valid = 1'b1;
    i_data  = 8'h3C;
    step();
    i_valid = 1'b0;
    e_ready = 1'b1;
    #1;
    chk("post_flush_first_valid", e_valid, 1);
    chk("post_flush_first_data", e_data, 8'h3C);
    step();
    e_ready = 1'b0;

    // Asynchronous reset mid-cycle with two stored.
    for (int j = 0; j < 2; j++) begin
      i_valid = 1'b1;
      i_data  = DATA_W'(8'hC0 + j);
      step();
    end
    i_valid = 1'b0;
    chk("pre_reset_count", count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_i_ready", i_ready, 1);
    chk("async_rst_e_valid", e_valid, 0);
    chk("async_rst_count", count, 0);
    step();
    rst     = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h5A;
    step();
    i_valid = 1'b0;
    chk("post_reset_accept_count", count, 1);
    e_ready = 1'b1;
    #1;
    chk("post_reset_data", e_data, 8'h5A);
    drain(10);
    step();
    step();
    chk("model_empty_at_end", model_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
